// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the wide add/sub sequencer: FSM encodings, default
// geometry and the opcode values driven by the issue logic onto the sub input.
package wide_add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int CHUNK_DEF  = 16;
  localparam int CHUNKS_DEF = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // idx needs at least one bit even when a single slice covers the whole word
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/result handshake bundle between ALU issue logic, the sequencer
// and writeback.
interface wide_add_seq_if #(parameter int W = 64);
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, sub, res_ready,
    input  start_ready, res_valid, result, cout, ovf, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, sub, res_ready,
    output start_ready, res_valid, result, cout, ovf, busy
  );
endinterface

// File: rtl/wide_add_seq_cla_chunk_adder.sv
// CHUNK-bit combinational adder made of cascaded 4-bit carry-lookahead groups.
module cla_chunk_adder #(
  parameter int CHUNK = 16
) (
  output logic [CHUNK-1:0] sum,
  output logic             cOut,
  input  logic [CHUNK-1:0] inA,
  input  logic [CHUNK-1:0] inB,
  input  logic             cIn
);

  localparam int GROUPS = CHUNK / 4;

  logic [GROUPS:0] w_gc;

  assign w_gc[0] = cIn;

  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_cla
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    assign w_p = inA[gi*4 +: 4] ^ inB[gi*4 +: 4];
    assign w_g = inA[gi*4 +: 4] & inB[gi*4 +: 4];

    assign w_c[0] = w_gc[gi];
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_gc[gi+1] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                      | (w_p[3] & w_p[2] & w_p[1] & w_g[0]) | ((&w_p) & w_c[0]);

    assign sum[gi*4 +: 4] = w_p ^ w_c;
  end

  assign cOut = w_gc[GROUPS];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle W-bit add/sub built by stepping one CHUNK-bit CLA over the word,
// LSB slice first, with a single carry flop between slices.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | ready for a request; operands latched on accept
//   RUN     | one slice per cycle, idx = slice being added
//   DONE    | result/cout/ovf held until writeback takes them
//   (2'b11) | illegal, falls back to IDLE
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int CHUNK  = CHUNK_DEF,
  parameter int CHUNKS = CHUNKS_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  wide_add_seq_if.slave bus
);

  localparam int W  = CHUNK * CHUNKS;
  localparam int IW = idx_width(CHUNKS);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;

  logic [CHUNK-1:0] w_sl_a;
  logic [CHUNK-1:0] w_sl_b;
  logic [CHUNK-1:0] w_sum;
  logic             w_sl_cout;
  logic             w_accept;
  logic             w_last;
  logic             w_ovf;

  always_comb begin
    w_sl_a = '0;
    w_sl_b = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (r_idx == IW'(i)) begin
        w_sl_a = r_a[i*CHUNK +: CHUNK];
        w_sl_b = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  cla_chunk_adder #(.CHUNK(CHUNK)) u_cla (
    .sum  (w_sum),
    .cOut (w_sl_cout),
    .inA  (w_sl_a),
    .inB  (w_sl_b),
    .cIn  (r_carry)
  );

  assign w_accept = (r_state == ST_IDLE) & bus.start_valid;
  assign w_last   = (r_idx == IW'(CHUNKS - 1));
  // r_b already holds ~B for a subtract, so one rule covers both operations
  assign w_ovf    = (r_a[W-1] == r_b[W-1]) & (w_sum[CHUNK-1] != r_a[W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start_valid) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)          w_state_nxt = ST_DONE;
      ST_DONE: if (bus.res_ready)   w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.op_a;
      r_b     <= bus.sub ? ~bus.op_b : bus.op_b;
      r_carry <= bus.sub;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      for (int i = 0; i < CHUNKS; i++) begin
        if (r_idx == IW'(i)) r_result[i*CHUNK +: CHUNK] <= w_sum;
      end
      r_carry <= w_sl_cout;
      if (w_last) begin
        r_cout <= w_sl_cout;
        r_ovf  <= w_ovf;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.start_ready = (r_state == ST_IDLE);
  assign bus.res_valid   = (r_state == ST_DONE);
  assign bus.busy        = (r_state == ST_RUN) | (r_state == ST_DONE);
  assign bus.result      = r_result;
  assign bus.cout        = r_cout;
  assign bus.ovf         = r_ovf;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and random checks of wide_add_seq in a 4-slice (64-bit) and a
// 1-slice (16-bit) build sharing clock and reset.
module tb_wide_add_seq;
  import wide_add_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wide_add_seq_if #(.W(64)) bus4();
  wide_add_seq_if #(.W(16)) bus1();

  wide_add_seq #(.CHUNK(16), .CHUNKS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  wide_add_seq #(.CHUNK(16), .CHUNKS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op4(input logic [63:0] a, input logic [63:0] b, input logic s,
                     output logic [63:0] r, output logic c, output logic v, output int lat);
    int n;
    bus4.op_a = a; bus4.op_b = b; bus4.sub = s;
    bus4.start_valid = 1'b1; bus4.res_ready = 1'b0;
    n = 0;
    while (!bus4.start_ready && n < 50) begin tick(); n++; end
    tick();
    bus4.start_valid = 1'b0;
    lat = 0;
    while (!bus4.res_valid && lat < 50) begin tick(); lat++; end
    checks++;
    if (lat >= 50) begin
      errors++;
      $display("FAIL op4_timeout: res_valid not seen, waited %0d cycles, required < 50", lat);
    end
    r = bus4.result; c = bus4.cout; v = bus4.ovf;
    bus4.res_ready = 1'b1;
    tick();
    bus4.res_ready = 1'b0;
  endtask

  task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic s,
                     output logic [15:0] r, output logic c, output logic v, output int lat);
    int n;
    bus1.op_a = a; bus1.op_b = b; bus1.sub = s;
    bus1.start_valid = 1'b1; bus1.res_ready = 1'b0;
    n = 0;
    while (!bus1.start_ready && n < 50) begin tick(); n++; end
    tick();
    bus1.start_valid = 1'b0;
    lat = 0;
    while (!bus1.res_valid && lat < 50) begin tick(); lat++; end
    checks++;
    if (lat >= 50) begin
      errors++;
      $display("FAIL op1_timeout: res_valid not seen, waited %0d cycles, required < 50", lat);
    end
    r = bus1.result; c = bus1.cout; v = bus1.ovf;
    bus1.res_ready = 1'b1;
    tick();
    bus1.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #22;
    checks++;
    if ({bus4.res_valid, bus4.busy, bus4.cout, bus4.ovf} !== 4'b0000 || bus4.result !== 64'h0) begin
      errors++;
      $display("FAIL reset_during4: rv/busy/cout/ovf=%b result=%h, required 0000 and 0",
               {bus4.res_valid, bus4.busy, bus4.cout, bus4.ovf}, bus4.result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus4.start_ready !== 1'b1 || bus4.res_valid !== 1'b0 || bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after4: sr=%b rv=%b busy=%b, required 1 0 0",
               bus4.start_ready, bus4.res_valid, bus4.busy);
    end
    checks++;
    if (bus1.start_ready !== 1'b1 || bus1.res_valid !== 1'b0 || bus1.busy !== 1'b0 ||
        bus1.result !== 16'h0 || bus1.cout !== 1'b0 || bus1.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_after1: sr=%b rv=%b busy=%b result=%h cout=%b ovf=%b, required 1 0 0 0000 0 0",
               bus1.start_ready, bus1.res_valid, bus1.busy, bus1.result, bus1.cout, bus1.ovf);
    end
  endtask

  task automatic test_carry_chain();
    logic [63:0] r; logic c, v; int lat;
    op4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, r, c, v, lat);
    checks++;
    if (r !== 64'h0 || c !== 1'b1 || v !== 1'b0) begin
      errors++;
      $display("FAIL carry_chain: result=%h cout=%b ovf=%b, required 0 1 0", r, c, v);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL latency4: %0d cycles, required 4", lat);
    end
  endtask

  task automatic test_sub_borrow();
    logic [63:0] r; logic c, v; int lat;
    op4(64'd5, 64'd7, OP_SUB, r, c, v, lat);
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE || c !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: result=%h cout=%b ovf=%b, required fffffffffffffffe 0 0", r, c, v);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] r; logic c, v; int lat;
    op4(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, OP_ADD, r, c, v, lat);
    checks++;
    if (r !== 64'h8000_0000_0000_0000 || c !== 1'b0 || v !== 1'b1) begin
      errors++;
      $display("FAIL ovf_add: result=%h cout=%b ovf=%b, required 8000000000000000 0 1", r, c, v);
    end
    op4(64'h8000_0000_0000_0000, 64'h1, OP_SUB, r, c, v, lat);
    checks++;
    if (r !== 64'h7FFF_FFFF_FFFF_FFFF || c !== 1'b1 || v !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sub: result=%h cout=%b ovf=%b, required 7fffffffffffffff 1 1", r, c, v);
    end
  endtask

  task automatic test_hold();
    int n;
    bus4.op_a = 64'h3; bus4.op_b = 64'h4; bus4.sub = OP_ADD;
    bus4.start_valid = 1'b1; bus4.res_ready = 1'b0;
    tick();
    bus4.start_valid = 1'b0;
    n = 0;
    while (!bus4.res_valid && n < 50) begin tick(); n++; end
    bus4.op_a = 64'h10; bus4.op_b = 64'h20;
    bus4.start_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus4.result !== 64'h7 || bus4.cout !== 1'b0 || bus4.ovf !== 1'b0 ||
          bus4.res_valid !== 1'b1 || bus4.start_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: result=%h cout=%b ovf=%b rv=%b sr=%b, required 7 0 0 1 0",
                 k, bus4.result, bus4.cout, bus4.ovf, bus4.res_valid, bus4.start_ready);
      end
    end
    bus4.res_ready = 1'b1;
    tick();
    bus4.res_ready = 1'b0;
    checks++;
    if (bus4.start_ready !== 1'b1 || bus4.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: sr=%b rv=%b, required 1 0", bus4.start_ready, bus4.res_valid);
    end
    tick();
    bus4.start_valid = 1'b0;
    checks++;
    if (bus4.busy !== 1'b1 || bus4.start_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_next_accept: busy=%b sr=%b, required 1 0", bus4.busy, bus4.start_ready);
    end
    n = 0;
    while (!bus4.res_valid && n < 50) begin tick(); n++; end
    checks++;
    if (bus4.result !== 64'h30 || n !== 4) begin
      errors++;
      $display("FAIL hold_next_result: result=%h after %0d cycles, required 30 after 4", bus4.result, n);
    end
    bus4.res_ready = 1'b1;
    tick();
    bus4.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] r; logic c, v; int lat;
    bus4.op_a = 64'h1111_1111_1111_FFFF; bus4.op_b = 64'h0000_0000_EEEF_1111;
    bus4.sub = OP_ADD; bus4.start_valid = 1'b1;
    tick();
    bus4.start_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (bus4.busy !== 1'b1 || bus4.result[31:0] !== 32'h0001_1110) begin
      errors++;
      $display("FAIL mid_partial: busy=%b result_lo=%h, required 1 00011110", bus4.busy, bus4.result[31:0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus4.result !== 64'h0 || bus4.cout !== 1'b0 || bus4.ovf !== 1'b0 ||
        bus4.res_valid !== 1'b0 || bus4.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: result=%h cout=%b ovf=%b rv=%b busy=%b, required all 0",
               bus4.result, bus4.cout, bus4.ovf, bus4.res_valid, bus4.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    op4(64'h1234, 64'h4321, OP_ADD, r, c, v, lat);
    checks++;
    if (r !== 64'h5555 || c !== 1'b0 || v !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_add: result=%h cout=%b ovf=%b, required 5555 0 0", r, c, v);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    logic prev_sr;
    int n;
    bus4.op_a = 64'd100; bus4.op_b = 64'd23; bus4.sub = OP_ADD;
    bus4.start_valid = 1'b1; bus4.res_ready = 1'b1;
    prev_sr = bus4.start_ready;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      tick();
      if (prev_sr) acc.push_back(cyc);
      if (bus4.res_valid) begin
        checks++;
        if (bus4.result !== 64'd123) begin
          errors++;
          $display("FAIL b2b_result: %h at cycle %0d, required 7b", bus4.result, cyc);
        end
      end
      prev_sr = bus4.start_ready;
    end
    bus4.start_valid = 1'b0;
    checks++;
    if (acc.size() < 3) begin
      errors++;
      $display("FAIL b2b_accepts: %0d accepts in 20 cycles, required >= 3", acc.size());
    end
    for (int i = 0; i + 1 < acc.size(); i++) begin
      checks++;
      if (acc[i+1] - acc[i] !== 6) begin
        errors++;
        $display("FAIL b2b_period%0d: %0d cycles, required 6", i, acc[i+1] - acc[i]);
      end
    end
    n = 0;
    while (!bus4.start_ready && n < 20) begin tick(); n++; end
    bus4.res_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [63:0] a, b, r, er;
    logic [15:0] a1, b1, r1, er1;
    logic s, c, v, ec, ev;
    logic signed [64:0] sx;
    logic signed [16:0] sx1;
    logic [64:0] ux;
    logic [16:0] ux1;
    int lat;
    for (int k = 0; k < 8; k++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      s = 1'($urandom_range(0, 1));
      if (k == 0) b = a;
      op4(a, b, s, r, c, v, lat);
      sx = s ? ($signed({a[63], a}) - $signed({b[63], b})) : ($signed({a[63], a}) + $signed({b[63], b}));
      ux = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
      er = ux[63:0];
      ec = s ? (a >= b) : ux[64];
      ev = sx[64] ^ sx[63];
      checks++;
      if (r !== er || c !== ec || v !== ev || lat !== 4) begin
        errors++;
        $display("FAIL rand4_%0d: a=%h b=%h sub=%b got %h/%b/%b lat %0d, required %h/%b/%b lat 4",
                 k, a, b, s, r, c, v, lat, er, ec, ev);
      end
    end
    for (int k = 0; k < 8; k++) begin
      a1 = 16'($urandom());
      b1 = 16'($urandom());
      s = 1'($urandom_range(0, 1));
      if (k == 0) begin a1 = 16'h7FFF; b1 = 16'h0001; s = OP_ADD; end
      op1(a1, b1, s, r1, c, v, lat);
      sx1 = s ? ($signed({a1[15], a1}) - $signed({b1[15], b1})) : ($signed({a1[15], a1}) + $signed({b1[15], b1}));
      ux1 = s ? ({1'b0, a1} - {1'b0, b1}) : ({1'b0, a1} + {1'b0, b1});
      er1 = ux1[15:0];
      ec = s ? (a1 >= b1) : ux1[16];
      ev = sx1[16] ^ sx1[15];
      checks++;
      if (r1 !== er1 || c !== ec || v !== ev || lat !== 1) begin
        errors++;
        $display("FAIL rand1_%0d: a=%h b=%h sub=%b got %h/%b/%b lat %0d, required %h/%b/%b lat 1",
                 k, a1, b1, s, r1, c, v, lat, er1, ec, ev);
      end
    end
  endtask

  initial begin
    bus4.start_valid = 1'b0; bus4.op_a = '0; bus4.op_b = '0; bus4.sub = 1'b0; bus4.res_ready = 1'b0;
    bus1.start_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.sub = 1'b0; bus1.res_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_sub_borrow();
    test_overflow();
    test_hold();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
